// File: rtl/commit_trace_checker_if.sv
// commit_trace_checker_if: expected-trace load channel and CPU commit tap.
// Store fields exist only when TRACE_MEMCHK_EN is defined.
interface commit_trace_checker_if #(
    parameter int unsigned XLEN = 32
);
    // Expected-trace producer channel
    logic            exp_valid;
    logic            exp_ready;
    logic [XLEN-1:0] exp_pc;
    logic            exp_we;
    logic [4:0]      exp_wa;
    logic [XLEN-1:0] exp_wd;
    logic            exp_last;
    // CPU retire tap
    logic            cmt_valid;
    logic [XLEN-1:0] cmt_pc;
    logic            cmt_we;
    logic [4:0]      cmt_wa;
    logic [XLEN-1:0] cmt_wd;
`ifdef TRACE_MEMCHK_EN
    logic            exp_mw;
    logic [XLEN-1:0] exp_ma;
    logic [XLEN-1:0] exp_md;
    logic            cmt_mw;
    logic [XLEN-1:0] cmt_ma;
    logic [XLEN-1:0] cmt_md;

    modport master (
        output exp_valid, exp_pc, exp_we, exp_wa, exp_wd, exp_last,
        output exp_mw, exp_ma, exp_md,
        input  exp_ready,
        output cmt_valid, cmt_pc, cmt_we, cmt_wa, cmt_wd,
        output cmt_mw, cmt_ma, cmt_md
    );
    modport slave (
        input  exp_valid, exp_pc, exp_we, exp_wa, exp_wd, exp_last,
        input  exp_mw, exp_ma, exp_md,
        output exp_ready,
        input  cmt_valid, cmt_pc, cmt_we, cmt_wa, cmt_wd,
        input  cmt_mw, cmt_ma, cmt_md
    );
`else
    modport master (
        output exp_valid, exp_pc, exp_we, exp_wa, exp_wd, exp_last,
        input  exp_ready,
        output cmt_valid, cmt_pc, cmt_we, cmt_wa, cmt_wd
    );
    modport slave (
        input  exp_valid, exp_pc, exp_we, exp_wa, exp_wd, exp_last,
        output exp_ready,
        input  cmt_valid, cmt_pc, cmt_we, cmt_wa, cmt_wd
    );
`endif
endinterface

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: scoreboard comparing CPU retire events against an expected
// trace queued in a FIFO. The first mismatch latches a sticky error code and index.
// Define TRACE_MEMCHK_EN to also carry and compare store (address/data) fields.
module commit_trace_checker #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 600,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  start_i,
    commit_trace_checker_if.slave trace_if,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [2:0]            err_code_o,
    output logic [CNT_W-1:0]      err_index_o,
    output logic [CNT_W-1:0]      count_o
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PC      = 3'd1;
    localparam logic [2:0] ERR_REG     = 3'd2;
    localparam logic [2:0] ERR_MEM     = 3'd3;
    localparam logic [2:0] ERR_UNDER   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

    state_e           r_state, w_state_nxt;
    logic [AW:0]      r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_err_index, w_err_index_nxt;
    logic [2:0]       r_err_code, w_err_code_nxt;
    logic [WD_W-1:0]  r_wdog, w_wdog_nxt;

    logic [XLEN-1:0]  r_pc_mem   [DEPTH];
    logic             r_we_mem   [DEPTH];
    logic [4:0]       r_wa_mem   [DEPTH];
    logic [XLEN-1:0]  r_wd_mem   [DEPTH];
    logic             r_last_mem [DEPTH];

    logic             w_full, w_empty, w_push, w_pop;
    logic [AW-1:0]    w_head;
    logic             w_pc_mis, w_reg_mis, w_mem_mis;

    // Extra MSB distinguishes full from empty when the index bits match
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = trace_if.exp_valid && !w_full;
    assign w_head  = r_rptr[AW-1:0];
    assign trace_if.exp_ready = !w_full;

    // Field comparison against the FIFO head; r0 writes never compare data
    assign w_pc_mis  = (trace_if.cmt_pc != r_pc_mem[w_head]);
    assign w_reg_mis = (trace_if.cmt_we != r_we_mem[w_head]) ||
                       (trace_if.cmt_we && r_we_mem[w_head] &&
                        ((trace_if.cmt_wa != r_wa_mem[w_head]) ||
                         ((r_wa_mem[w_head] != 5'd0) &&
                          (trace_if.cmt_wd != r_wd_mem[w_head]))));

`ifdef TRACE_MEMCHK_EN
    logic             r_mw_mem [DEPTH];
    logic [XLEN-1:0]  r_ma_mem [DEPTH];
    logic [XLEN-1:0]  r_md_mem [DEPTH];

    assign w_mem_mis = (trace_if.cmt_mw != r_mw_mem[w_head]) ||
                       (trace_if.cmt_mw && r_mw_mem[w_head] &&
                        ((trace_if.cmt_ma != r_ma_mem[w_head]) ||
                         (trace_if.cmt_md != r_md_mem[w_head])));

    // Store-field storage, written alongside the base entry
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mw_mem[r_wptr[AW-1:0]] <= trace_if.exp_mw;
            r_ma_mem[r_wptr[AW-1:0]] <= trace_if.exp_ma;
            r_md_mem[r_wptr[AW-1:0]] <= trace_if.exp_md;
        end
    end
`else
    assign w_mem_mis = 1'b0;
`endif

    // Entry storage; contents need no reset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wptr[AW-1:0]]   <= trace_if.exp_pc;
            r_we_mem[r_wptr[AW-1:0]]   <= trace_if.exp_we;
            r_wa_mem[r_wptr[AW-1:0]]   <= trace_if.exp_wa;
            r_wd_mem[r_wptr[AW-1:0]]   <= trace_if.exp_wd;
            r_last_mem[r_wptr[AW-1:0]] <= trace_if.exp_last;
        end
    end

    // Next-state: FSM transitions, compare outcome, counters and watchdog
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_err_index_nxt = r_err_index;
        w_err_code_nxt  = r_err_code;
        w_wdog_nxt      = r_wdog;
        w_pop           = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_nxt = StRun;
                    w_wdog_nxt  = '0;
                end
            end
            StRun: begin
                if (trace_if.cmt_valid) begin
                    w_wdog_nxt = '0;
                    if (r_count != '1) begin
                        w_count_nxt = r_count + 1'b1;
                    end
                    if (w_empty) begin
                        // A same-cycle push is not visible here: underflow wins
                        w_state_nxt     = StFail;
                        w_err_code_nxt  = ERR_UNDER;
                        w_err_index_nxt = r_count;
                    end else begin
                        w_pop = 1'b1;
                        if (w_pc_mis || w_reg_mis || w_mem_mis) begin
                            w_state_nxt     = StFail;
                            w_err_index_nxt = r_count;
                            if (w_pc_mis) begin
                                w_err_code_nxt = ERR_PC;
                            end else if (w_reg_mis) begin
                                w_err_code_nxt = ERR_REG;
                            end else begin
                                w_err_code_nxt = ERR_MEM;
                            end
                        end else if (r_last_mem[w_head]) begin
                            w_state_nxt = StPass;
                        end
                    end
                end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = StFail;
                    w_err_code_nxt  = ERR_TIMEOUT;
                    w_err_index_nxt = r_count;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State register, FIFO pointers and latched status
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_err_index <= '0;
            r_err_code  <= ERR_NONE;
            r_wdog      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_err_index <= w_err_index_nxt;
            r_err_code  <= w_err_code_nxt;
            r_wdog      <= w_wdog_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign pass_o      = (r_state == StPass);
    assign fail_o      = (r_state == StFail);
    assign done_o      = pass_o || fail_o;
    assign err_code_o  = r_err_code;
    assign err_index_o = r_err_index;
    assign count_o     = r_count;

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb_commit_trace_checker: directed scenarios for commit_trace_checker. Stimulus
// queues the expected final status; a monitor compares it when done_o rises.
// Store-field scenario is built only when TRACE_MEMCHK_EN is defined.
module tb_commit_trace_checker;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 600;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        last;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
    } ent_t;

    typedef struct {
        logic        pass;
        logic        fail;
        logic [2:0]  code;
        logic [15:0] index;
        logic [15:0] count;
    } res_t;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             done_o, pass_o, fail_o;
    logic [2:0]       err_code_o;
    logic [CNT_W-1:0] err_index_o, count_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   seen    = 1'b0;
    res_t exp_q[$];
    ent_t z = '0;

    commit_trace_checker_if #(.XLEN(XLEN)) bus_if ();

    commit_trace_checker #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .trace_if(bus_if),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .err_code_o(err_code_o),
        .err_index_o(err_index_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic last);
        ent_t e;
        e = '0;
        e.pc = pc; e.we = we; e.wa = wa; e.wd = wd; e.last = last;
        return e;
    endfunction

    // One clock of stimulus: every input driven at the negedge before the capturing edge
    task automatic step(input logic pv, input ent_t pe, input logic cv, input ent_t ce,
                        input logic st);
        @(negedge clk_i);
        bus_if.exp_valid = pv;  bus_if.exp_pc = pe.pc;  bus_if.exp_we = pe.we;
        bus_if.exp_wa = pe.wa;  bus_if.exp_wd = pe.wd;  bus_if.exp_last = pe.last;
        bus_if.cmt_valid = cv;  bus_if.cmt_pc = ce.pc;  bus_if.cmt_we = ce.we;
        bus_if.cmt_wa = ce.wa;  bus_if.cmt_wd = ce.wd;
`ifdef TRACE_MEMCHK_EN
        bus_if.exp_mw = pe.mw;  bus_if.exp_ma = pe.ma;  bus_if.exp_md = pe.md;
        bus_if.cmt_mw = ce.mw;  bus_if.cmt_ma = ce.ma;  bus_if.cmt_md = ce.md;
`endif
        start_i = st;
    endtask

    task automatic push(input ent_t e);   step(1'b1, e, 1'b0, z, 1'b0); endtask
    task automatic commit(input ent_t e); step(1'b0, z, 1'b1, e, 1'b0); endtask
    task automatic idle();                step(1'b0, z, 1'b0, z, 1'b0); endtask
    task automatic start();               step(1'b0, z, 1'b0, z, 1'b1); endtask
    task automatic settle();              @(posedge clk_i); #1; endtask

    task automatic expect_res(input logic p, input logic f, input logic [2:0] c,
                              input logic [15:0] idx, input logic [15:0] cnt);
        res_t r;
        r.pass = p; r.fail = f; r.code = c; r.index = idx; r.count = cnt;
        exp_q.push_back(r);
    endtask

    // Every queued result must have been consumed by the monitor
    task automatic finish_case(input string name);
        repeat (2) @(posedge clk_i);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_result_missing: got %0d pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, z, 1'b0, z, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    // Monitor: compare latched status against the scoreboard when done_o rises
    always @(negedge clk_i) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (done_o && !seen) begin
            res_t r;
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got code %0d, want no result", err_code_o);
            end else begin
                r = exp_q.pop_front();
                chk("mon_pass", pass_o, r.pass);
                chk("mon_fail", fail_o, r.fail);
                chk("mon_code", err_code_o, r.code);
                chk("mon_index", err_index_o, r.index);
                chk("mon_count", count_o, r.count);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        do_reset();
        settle();
        chk("rst_done", done_o, 1'b0);
        chk("rst_pass", pass_o, 1'b0);
        chk("rst_fail", fail_o, 1'b0);
        chk("rst_code", err_code_o, 3'd0);
        chk("rst_index", err_index_o, 16'd0);
        chk("rst_count", count_o, 16'd0);
        chk("rst_ready", bus_if.exp_ready, 1'b1);

        // Three matching entries, last on third -> PASS with count 3
        push(mk(32'h0, 1'b1, 5'd1, 32'd10, 1'b0));
        push(mk(32'h4, 1'b1, 5'd2, 32'd20, 1'b0));
        push(mk(32'h8, 1'b0, 5'd0, 32'd0, 1'b1));
        start();
        commit(mk(32'h0, 1'b1, 5'd1, 32'd10, 1'b0));
        commit(mk(32'h4, 1'b1, 5'd2, 32'd20, 1'b0));
        expect_res(1'b1, 1'b0, 3'd0, 16'd0, 16'd3);
        commit(mk(32'h8, 1'b0, 5'd0, 32'd0, 1'b0));
        idle();
        finish_case("pass3");

        // PC mismatch on entry 1 (wd also wrong: PC has priority); later commits ignored
        do_reset();
        push(mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0));
        push(mk(32'h4, 1'b1, 5'd2, 32'd20, 1'b0));
        push(mk(32'h8, 1'b0, 5'd0, 32'd0, 1'b1));
        start();
        commit(mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0));
        expect_res(1'b0, 1'b1, 3'd1, 16'd1, 16'd2);
        commit(mk(32'h8, 1'b1, 5'd2, 32'd99, 1'b0));
        commit(mk(32'h8, 1'b0, 5'd0, 32'd0, 1'b0));
        commit(mk(32'hc, 1'b0, 5'd0, 32'd0, 1'b0));
        idle();
        settle();
        chk("sticky_fail", fail_o, 1'b1);
        chk("sticky_code", err_code_o, 3'd1);
        chk("sticky_index", err_index_o, 16'd1);
        chk("sticky_count", count_o, 16'd2);
        finish_case("pc_mis");

        // r0 write ignores data; wa=3 with data mismatch -> REG error
        do_reset();
        push(mk(32'h0, 1'b1, 5'd0, 32'd5, 1'b0));
        push(mk(32'h4, 1'b1, 5'd3, 32'd5, 1'b1));
        start();
        commit(mk(32'h0, 1'b1, 5'd0, 32'd9, 1'b0));
        expect_res(1'b0, 1'b1, 3'd2, 16'd1, 16'd2);
        commit(mk(32'h4, 1'b1, 5'd3, 32'd6, 1'b0));
        idle();
        finish_case("reg_mis");

        // Fill, drop on full, push+pop at DEPTH-1, then underflow proves the drop
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) push(mk(32'(4 * i), 1'b0, 5'd0, 32'd0, 1'b0));
        settle();
        chk("ready_at_depth_m1", bus_if.exp_ready, 1'b1);
        start();
        step(1'b1, mk(32'(4 * (DEPTH - 1)), 1'b0, 5'd0, 32'd0, 1'b0),
             1'b1, mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0), 1'b0);
        settle();
        chk("ready_after_push_pop", bus_if.exp_ready, 1'b1);
        push(mk(32'(4 * DEPTH), 1'b0, 5'd0, 32'd0, 1'b0));
        settle();
        chk("ready_full", bus_if.exp_ready, 1'b0);
        push(mk(32'(4 * (DEPTH + 1)), 1'b0, 5'd0, 32'd0, 1'b1));
        settle();
        chk("ready_full_after_drop", bus_if.exp_ready, 1'b0);
        for (int i = 1; i <= DEPTH; i++) commit(mk(32'(4 * i), 1'b0, 5'd0, 32'd0, 1'b0));
        settle();
        chk("no_pass_before_drain", done_o, 1'b0);
        expect_res(1'b0, 1'b1, 3'd4, 16'(DEPTH + 1), 16'(DEPTH + 2));
        commit(mk(32'(4 * (DEPTH + 1)), 1'b0, 5'd0, 32'd0, 1'b1));
        idle();
        finish_case("full_drop");

        // Commit on empty FIFO with simultaneous push -> underflow
        do_reset();
        start();
        expect_res(1'b0, 1'b1, 3'd4, 16'd0, 16'd1);
        step(1'b1, mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0),
             1'b1, mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0), 1'b0);
        idle();
        finish_case("underflow");

        // Watchdog restarts at a commit, then trips after TIMEOUT idle cycles
        do_reset();
        push(mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0));
        start();
        repeat (100) idle();
        commit(mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0));
        repeat (TIMEOUT - 5) idle();
        settle();
        chk("no_early_timeout", fail_o, 1'b0);
        expect_res(1'b0, 1'b1, 3'd5, 16'd1, 16'd1);
        for (int i = 0; i < 50 && !done_o; i++) idle();
        finish_case("timeout");

`ifdef TRACE_MEMCHK_EN
        // Store address 0x10 data 7 vs actual data 8 -> MEM error on entry 1
        do_reset();
        begin
            ent_t e0, e1, c1;
            e0 = mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0);
            e0.mw = 1'b1; e0.ma = 32'h10; e0.md = 32'd7;
            e1 = mk(32'h4, 1'b0, 5'd0, 32'd0, 1'b1);
            e1.mw = 1'b1; e1.ma = 32'h10; e1.md = 32'd7;
            c1 = e1;
            c1.md = 32'd8;
            push(e0);
            push(e1);
            start();
            commit(e0);
            expect_res(1'b0, 1'b1, 3'd3, 16'd1, 16'd2);
            commit(c1);
        end
        idle();
        finish_case("mem_mis");
`endif

        // Asynchronous reset mid-run discards all state including FIFO contents
        do_reset();
        push(mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0));
        push(mk(32'h4, 1'b0, 5'd0, 32'd0, 1'b1));
        start();
        commit(mk(32'h0, 1'b0, 5'd0, 32'd0, 1'b0));
        settle();
        chk("midrun_count", count_o, 16'd1);
        #2;
        rst_n = 1'b0;
        bus_if.exp_valid = 1'b0;
        bus_if.cmt_valid = 1'b0;
        #1;
        chk("async_rst_count", count_o, 16'd0);
        chk("async_rst_done", done_o, 1'b0);
        chk("async_rst_ready", bus_if.exp_ready, 1'b1);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        start();
        expect_res(1'b0, 1'b1, 3'd4, 16'd0, 16'd1);
        commit(mk(32'h4, 1'b0, 5'd0, 32'd0, 1'b0));
        idle();
        finish_case("midrun_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
